ttt_game_ctrl: RTL and testbench
================================

// Module: ttt_game_ctrl
// PURPOSE
//  Turn sequencer for the tic-tac-toe board. Takes decoded, single-cycle keypad strobes and runs the game:
//  - validates each move against the board; commits it for the player whose turn it is;
//  - checks for 3-in-a-row or a full board; alternates turns; enforces an optional per-turn timeout.
//  Sits between the keypad scanner and the 7-segment / dot-matrix display blocks, which read board/turn/result.
// PARAMETERS
//  TIMEOUT_CYC  0   clk cycles allowed per turn before forfeit; 0 disables the timeout
//  TIMEOUT_W    32  width of the turn-timer counter (must hold TIMEOUT_CYC)
// PORTS
//  clk          in   1   system clock (25 MHz board clock)
//  rst          in   1   synchronous reset, active-high
//  start        in   1   1-cycle pulse: leave IDLE and begin a game
//  key_valid    in   1   1-cycle strobe: key_code holds a new key press
//  key_code     in   4   0..9 keypad digit; 1..9 = cell, row-major from top-left; 0 = restart
//  board        out  18  cell k at bits [19-2k:18-2k]; 2'b00 empty, 2'b01 X, 2'b10 O
//  turn_o       out  1   1 = O to move, 0 = X to move
//  result       out  2   00 in progress, 01 X wins, 10 O wins, 11 draw
//  game_state   out  2   00 IDLE, 01 PLAY, 10 CHECK, 11 OVER
//  move_cnt     out  4   moves committed this game, 0..9
//  move_ack     out  1   1-cycle pulse: move committed
//  illegal      out  1   1-cycle pulse: key rejected in PLAY
//  timeout      out  1   1-cycle pulse: turn forfeited
// BEHAVIOUR
//  - Clock/reset: one clock, clk; reset rst is synchronous, active-high.
//  - Reset (any state, mid-game included), next edge:
//    - state = IDLE; board = 0; turn_o = 0; result = 00; move_cnt = 0;
//    - all pulses 0; turn timer = 0.
//  - IDLE:
//    - board, result, move_cnt, turn_o held at 0; key_valid ignored.
//    - start = 1 -> PLAY next cycle.
//    - start and key_valid in the same cycle: enter PLAY, drop the key.
//  - PLAY, key_valid with code k in 1..9 and cell k empty:
//    - next edge: cell k <= (turn_o ? 2'b10 : 2'b01); move_cnt += 1; move_ack = 1; timer cleared; -> CHECK.
//  - PLAY, key_valid with code 0, or with cell k occupied:
//    - illegal = 1 for one cycle; board, turn and timer unchanged; stay in PLAY.
//  - PLAY, turn timer (TIMEOUT_CYC != 0):
//    - counts every PLAY cycle; on reaching TIMEOUT_CYC-1: turn_o toggles, timeout = 1, timer = 0; board unchanged.
//    - Valid key in the same cycle as expiry: the move wins; no timeout pulse.
//  - CHECK (exactly 1 cycle; key_valid ignored, not queued). Tests only the mover's mark on the committed board:
//    - 3-in-a-row on any of 8 lines (3 rows, 3 cols, 2 diagonals) -> result = 01 (X) / 10 (O); -> OVER.
//    - else move_cnt == 9 -> result = 11; -> OVER.
//    - else turn_o toggles; -> PLAY.
//    - A win on the 9th move reports the win, not a draw.
//  - OVER:
//    - board, result, turn_o frozen.
//    - key_valid with code 0 -> IDLE next cycle, clearing board/result/move_cnt/turn_o.
//    - other keys ignored; no illegal pulse.
//  - Latency: key strobe to board update = 1 cycle; to result valid = 2 cycles.
//  - move_cnt saturates at 9 (unreachable above by construction).
//  - All outputs registered; pulses never assert in the same cycle as reset.
// STRUCTURE
//  - Package ttt_pkg:
//    - state encodings IDLE/PLAY/CHECK/OVER;
//    - result codes RES_NONE/RES_X/RES_O/RES_DRAW;
//    - cell codes CELL_EMPTY/CELL_X/CELL_O;
//    - KEY_RESTART = 0.
//  - Sub-module ttt_line_check: combinational; in: 9-bit occupancy mask of one player; out: win.
//    - Instantiated twice (X mask = board even bits, O mask = odd bits).
//  - Top holds the FSM, board register, move counter, turn timer.
// TESTING
//  1 rst; start; keys 1,4,2,5,3 -> board = 18'b01_01_01_10_10_00_00_00_00;
//    result = 01 two cycles after key 3; state OVER; move_cnt = 5.
//  2 keys 5 then 5 -> second key: illegal pulse; board[9:8] = 01; turn_o = 1; move_cnt = 1.
//  3 X:1,3,4,8,9  O:2,5,6,7 -> result = 11 after 9th move; every move_ack seen; no illegal.
//  4 TIMEOUT_CYC = 10; start; idle 10 cycles -> timeout pulse, turn_o = 1.
//    Then key 1 on the expiry cycle -> move taken (cell 1 = O), no timeout pulse.
//  5 OVER, key 7 -> ignored.
//    Key 0 -> IDLE, board = 0, result = 00.
//    rst asserted mid-CHECK -> IDLE next edge, all outputs 0.
//  6 key_valid during CHECK, and start+key same cycle in IDLE -> both keys dropped; board unchanged.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared encodings and board helpers for the tic-tac-toe turn sequencer.
package ttt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        CHECK = 2'b10,
        OVER  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_X    = 2'b01,
        RES_O    = 2'b10,
        RES_DRAW = 2'b11
    } result_e;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b01,
        CELL_O     = 2'b10
    } cell_e;

    localparam logic [3:0] KEY_RESTART = 4'd0;
    localparam int         NUM_CELLS   = 9;
    localparam int         NUM_LINES   = 8;
    localparam logic [3:0] MAX_MOVES   = 4'd9;

    // Winning lines as occupancy masks; mask bit (k-1) stands for cell k.
    localparam logic [NUM_LINES-1:0][NUM_CELLS-1:0] WIN_LINES = {
        9'b000_000_111,  // row 1: cells 1,2,3
        9'b000_111_000,  // row 2: cells 4,5,6
        9'b111_000_000,  // row 3: cells 7,8,9
        9'b001_001_001,  // col 1: cells 1,4,7
        9'b010_010_010,  // col 2: cells 2,5,8
        9'b100_100_100,  // col 3: cells 3,6,9
        9'b100_010_001,  // diagonal: cells 1,5,9
        9'b001_010_100   // anti-diagonal: cells 3,5,7
    };

    // Low bit position of cell k (1..9) inside the 18-bit board vector.
    function automatic int cell_lsb(input int k);
        return 18 - 2 * k;
    endfunction

    // Contents of the cell addressed by a key code; non-cell codes read as empty.
    function automatic logic [1:0] get_cell(input logic [17:0] b, input logic [3:0] k);
        logic [1:0] c;
        c = CELL_EMPTY;
        for (int i = 1; i <= NUM_CELLS; i++) begin
            if (k == 4'(i)) c = b[cell_lsb(i) +: 2];
        end
        return c;
    endfunction

    // Board with the cell addressed by a key code replaced by v.
    function automatic logic [17:0] set_cell(input logic [17:0] b, input logic [3:0] k,
                                             input logic [1:0] v);
        logic [17:0] r;
        r = b;
        for (int i = 1; i <= NUM_CELLS; i++) begin
            if (k == 4'(i)) r[cell_lsb(i) +: 2] = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational 3-in-a-row detector for one player's occupancy mask.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [NUM_CELLS-1:0] mask,
    output logic                 win
);

    // Any of the eight lines fully covered by the mask is a win.
    always_comb begin
        win = 1'b0;
        for (int l = 0; l < NUM_LINES; l++) begin
            if ((mask & WIN_LINES[l]) == WIN_LINES[l]) win = 1'b1;
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer: validates key strobes, commits moves, detects
// wins/draws, alternates turns and optionally forfeits a turn on timeout.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int TIMEOUT_CYC = 0,
    parameter int TIMEOUT_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [17:0] board,
    output logic        turn_o,
    output logic [1:0]  result,
    output logic [1:0]  game_state,
    output logic [3:0]  move_cnt,
    output logic        move_ack,
    output logic        illegal,
    output logic        timeout
);

    localparam bit                   TIMER_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    state_e                 state_q, state_d;
    logic [17:0]            board_q, board_d;
    logic                   turn_q, turn_d;
    result_e                result_q, result_d;
    logic [3:0]             move_cnt_q, move_cnt_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;
    logic                   move_ack_q, move_ack_d;
    logic                   illegal_q, illegal_d;
    logic                   timeout_q, timeout_d;

    logic [NUM_CELLS-1:0]   x_mask, o_mask;
    logic                   x_win, o_win, mover_win;
    logic                   key_is_cell;
    logic                   cell_free;

    // Split the board into per-player occupancy: X on even bits, O on odd bits.
    always_comb begin
        x_mask = '0;
        o_mask = '0;
        for (int k = 1; k <= NUM_CELLS; k++) begin
            x_mask[k-1] = board_q[cell_lsb(k)];
            o_mask[k-1] = board_q[cell_lsb(k) + 1];
        end
    end

    ttt_line_check u_x_check (
        .mask (x_mask),
        .win  (x_win)
    );

    ttt_line_check u_o_check (
        .mask (o_mask),
        .win  (o_win)
    );

    assign mover_win   = turn_q ? o_win : x_win;
    assign key_is_cell = (key_code >= 4'd1) && (key_code <= 4'd9);
    assign cell_free   = (get_cell(board_q, key_code) == CELL_EMPTY);

    // Next-state, board, turn, result, counter, timer and pulse logic.
    always_comb begin
        // NOTE: every variable gets its hold/idle value first, so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        board_d    = board_q;
        turn_d     = turn_q;
        result_d   = result_q;
        move_cnt_d = move_cnt_q;
        timer_d    = timer_q;
        move_ack_d = 1'b0;
        illegal_d  = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                board_d    = '0;
                turn_d     = 1'b0;
                result_d   = RES_NONE;
                move_cnt_d = '0;
                timer_d    = '0;
                if (start) state_d = PLAY;
            end

            PLAY: begin
                if (key_valid) begin
                    if (key_is_cell && cell_free) begin
                        // A legal move beats a timer expiring in the same cycle.
                        board_d    = set_cell(board_q, key_code, turn_q ? CELL_O : CELL_X);
                        move_cnt_d = (move_cnt_q == MAX_MOVES) ? MAX_MOVES : move_cnt_q + 4'd1;
                        move_ack_d = 1'b1;
                        timer_d    = '0;
                        state_d    = CHECK;
                    end else begin
                        // Rejected key: board, turn and timer all hold.
                        illegal_d = 1'b1;
                    end
                end else if (TIMER_EN) begin
                    if (timer_q == TIMER_LAST) begin
                        turn_d    = ~turn_q;
                        timeout_d = 1'b1;
                        timer_d   = '0;
                    end else begin
                        timer_d = timer_q + TIMEOUT_W'(1);
                    end
                end
            end

            CHECK: begin
                // Only the player who just moved can have completed a line.
                if (mover_win) begin
                    result_d = turn_q ? RES_O : RES_X;
                    state_d  = OVER;
                end else if (move_cnt_q == MAX_MOVES) begin
                    result_d = RES_DRAW;
                    state_d  = OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = PLAY;
                end
            end

            OVER: begin
                if (key_valid && (key_code == KEY_RESTART)) begin
                    board_d    = '0;
                    turn_d     = 1'b0;
                    result_d   = RES_NONE;
                    move_cnt_d = '0;
                    timer_d    = '0;
                    state_d    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= IDLE;
            board_q    <= '0;
            turn_q     <= 1'b0;
            result_q   <= RES_NONE;
            move_cnt_q <= '0;
            timer_q    <= '0;
            move_ack_q <= 1'b0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            turn_q     <= turn_d;
            result_q   <= result_d;
            move_cnt_q <= move_cnt_d;
            timer_q    <= timer_d;
            move_ack_q <= move_ack_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    assign board      = board_q;
    assign turn_o     = turn_q;
    assign result     = result_q;
    assign game_state = state_q;
    assign move_cnt   = move_cnt_q;
    assign move_ack   = move_ack_q;
    assign illegal    = illegal_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: directed game scenarios plus random
// key traffic compared every cycle against a game-rules reference model.
module tb_ttt_game_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance without turn timer.
    logic        rst, start, key_valid;
    logic [3:0]  key_code;
    logic [17:0] board;
    logic        turn_o;
    logic [1:0]  result, game_state;
    logic [3:0]  move_cnt;
    logic        move_ack, illegal, timeout;

    // Instance with a 10-cycle turn timer.
    logic        rst_t, start_t, key_valid_t;
    logic [3:0]  key_code_t;
    logic [17:0] board_t;
    logic        turn_o_t;
    logic [1:0]  result_t, game_state_t;
    logic [3:0]  move_cnt_t;
    logic        move_ack_t, illegal_t, timeout_t;

    ttt_game_ctrl #(.TIMEOUT_CYC(0), .TIMEOUT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_code(key_code),
        .board(board), .turn_o(turn_o), .result(result), .game_state(game_state),
        .move_cnt(move_cnt), .move_ack(move_ack), .illegal(illegal), .timeout(timeout)
    );

    ttt_game_ctrl #(.TIMEOUT_CYC(10), .TIMEOUT_W(8)) dut_t (
        .clk(clk), .rst(rst_t), .start(start_t), .key_valid(key_valid_t), .key_code(key_code_t),
        .board(board_t), .turn_o(turn_o_t), .result(result_t), .game_state(game_state_t),
        .move_cnt(move_cnt_t), .move_ack(move_ack_t), .illegal(illegal_t), .timeout(timeout_t)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    string cur   = "init";

    // Reference model: phase 0 idle, 1 play, 2 check, 3 over; cells 0 empty, 1 X, 2 O.
    int m_cells [1:9];
    int m_phase, m_turn, m_res, m_cnt, m_ack, m_ill;
    int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                         '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
    int draw_seq [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
    int win9_seq [9] = '{1, 2, 3, 4, 6, 5, 8, 7, 9};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit has_line(input int mark);
        for (int l = 0; l < 8; l++) begin
            if (m_cells[lines[l][0]] == mark && m_cells[lines[l][1]] == mark &&
                m_cells[lines[l][2]] == mark) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] b;
        b = '0;
        for (int k = 1; k <= 9; k++) b = b | (18'(m_cells[k]) << (18 - 2 * k));
        return b;
    endfunction

    task automatic model_step(input bit r, input bit s, input bit kv, input int kc);
        m_ack = 0;
        m_ill = 0;
        if (r) begin
            for (int k = 1; k <= 9; k++) m_cells[k] = 0;
            m_phase = 0; m_turn = 0; m_res = 0; m_cnt = 0;
        end else begin
            case (m_phase)
                0: if (s) m_phase = 1;
                1: if (kv) begin
                       if (kc >= 1 && kc <= 9 && m_cells[kc] == 0) begin
                           m_cells[kc] = (m_turn == 1) ? 2 : 1;
                           m_cnt++;
                           m_ack = 1;
                           m_phase = 2;
                       end else begin
                           m_ill = 1;
                       end
                   end
                2: begin
                       if (has_line((m_turn == 1) ? 2 : 1)) begin
                           m_res = (m_turn == 1) ? 2 : 1;
                           m_phase = 3;
                       end else if (m_cnt == 9) begin
                           m_res = 3;
                           m_phase = 3;
                       end else begin
                           m_turn = 1 - m_turn;
                           m_phase = 1;
                       end
                   end
                default: if (kv && kc == 0) begin
                       for (int k = 1; k <= 9; k++) m_cells[k] = 0;
                       m_phase = 0; m_turn = 0; m_res = 0; m_cnt = 0;
                   end
            endcase
        end
    endtask

    task automatic compare_model();
        check({cur, ".board"},   32'(board),      32'(model_board()));
        check({cur, ".turn"},    32'(turn_o),     32'(m_turn));
        check({cur, ".result"},  32'(result),     32'(m_res));
        check({cur, ".state"},   32'(game_state), 32'(m_phase));
        check({cur, ".cnt"},     32'(move_cnt),   32'(m_cnt));
        check({cur, ".ack"},     32'(move_ack),   32'(m_ack));
        check({cur, ".illegal"}, 32'(illegal),    32'(m_ill));
        check({cur, ".timeout"}, 32'(timeout),    32'd0);
    endtask

    // One clock on the untimed instance, mirrored in the model and compared.
    task automatic cycle(input bit r, input bit s, input bit kv, input int kc);
        rst = r; start = s; key_valid = kv; key_code = 4'(kc);
        model_step(r, s, kv, kc);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // One clock on the timed instance.
    task automatic tcycle(input bit r, input bit s, input bit kv, input int kc);
        rst_t = r; start_t = s; key_valid_t = kv; key_code_t = 4'(kc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit r, s, kv;
        int kc;
        int empt [$];

        rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        rst_t = 1'b1; start_t = 1'b0; key_valid_t = 1'b0; key_code_t = 4'd0;

        // Turn timeout on the timed instance; the untimed one sits in reset.
        cur = "t4";
        tcycle(1, 0, 0, 0);
        check("t4.reset_state", 32'(game_state_t), 32'd0);
        check("t4.reset_board", 32'(board_t), 32'd0);
        tcycle(0, 1, 0, 0);
        check("t4.play", 32'(game_state_t), 32'd1);
        for (int i = 0; i < 9; i++) begin
            tcycle(0, 0, 0, 0);
            check("t4.no_early_timeout", 32'(timeout_t), 32'd0);
        end
        tcycle(0, 0, 0, 0);
        check("t4.timeout_pulse", 32'(timeout_t), 32'd1);
        check("t4.turn_to_o", 32'(turn_o_t), 32'd1);
        check("t4.board_kept", 32'(board_t), 32'd0);
        for (int i = 0; i < 9; i++) begin
            tcycle(0, 0, 0, 0);
            check("t4.no_second_timeout", 32'(timeout_t), 32'd0);
        end
        tcycle(0, 0, 1, 1);
        check("t4.move_on_expiry_ack", 32'(move_ack_t), 32'd1);
        check("t4.move_on_expiry_no_to", 32'(timeout_t), 32'd0);
        check("t4.cell1_is_o", 32'(board_t[17:16]), 32'd2);
        check("t4.cnt", 32'(move_cnt_t), 32'd1);
        tcycle(0, 0, 0, 0);
        check("t4.back_to_play", 32'(game_state_t), 32'd1);
        check("t4.turn_to_x", 32'(turn_o_t), 32'd0);
        rst_t = 1'b1;

        // X wins on row 1 after keys 1,4,2,5,3.
        cur = "t1";
        cycle(1, 0, 0, 0);
        check("t1.reset_state", 32'(game_state), 32'd0);
        check("t1.reset_board", 32'(board), 32'd0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 1); cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 4); cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 2); cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 5); cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 3);
        check("t1.board", 32'(board), 32'(18'b01_01_01_10_10_00_00_00_00));
        check("t1.result_not_yet", 32'(result), 32'd0);
        cycle(0, 0, 0, 0);
        check("t1.result_x", 32'(result), 32'd1);
        check("t1.over", 32'(game_state), 32'd3);
        check("t1.cnt", 32'(move_cnt), 32'd5);

        // OVER ignores non-restart keys; key 0 returns to IDLE.
        cur = "t5";
        cycle(0, 0, 1, 7);
        check("t5.key7_state", 32'(game_state), 32'd3);
        check("t5.key7_no_illegal", 32'(illegal), 32'd0);
        check("t5.key7_board", 32'(board), 32'(18'b01_01_01_10_10_00_00_00_00));
        cycle(0, 0, 1, 0);
        check("t5.restart_state", 32'(game_state), 32'd0);
        check("t5.restart_board", 32'(board), 32'd0);
        check("t5.restart_result", 32'(result), 32'd0);

        // Occupied cell is rejected.
        cur = "t2";
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 5); cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 5);
        check("t2.illegal", 32'(illegal), 32'd1);
        check("t2.cell5_x", 32'(board[9:8]), 32'd1);
        check("t2.turn_o", 32'(turn_o), 32'd1);
        check("t2.cnt", 32'(move_cnt), 32'd1);
        cycle(0, 0, 1, 0);
        check("t2.key0_illegal", 32'(illegal), 32'd1);

        // Keys during CHECK and start+key in IDLE are dropped; reset mid-CHECK.
        cur = "t6";
        cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 2);
        check("t6.check_key_dropped", 32'(board[15:14]), 32'd0);
        check("t6.check_no_ack", 32'(move_ack), 32'd0);
        cycle(0, 0, 1, 3);
        cycle(1, 0, 0, 0);
        check("t6.rst_mid_check_state", 32'(game_state), 32'd0);
        check("t6.rst_mid_check_board", 32'(board), 32'd0);
        check("t6.rst_mid_check_cnt", 32'(move_cnt), 32'd0);
        cycle(0, 1, 1, 5);
        check("t6.start_key_state", 32'(game_state), 32'd1);
        check("t6.start_key_board", 32'(board), 32'd0);

        // Full-board draw.
        cur = "t3";
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 1, draw_seq[i]);
            check("t3.ack", 32'(move_ack), 32'd1);
            check("t3.no_illegal", 32'(illegal), 32'd0);
            cycle(0, 0, 0, 0);
        end
        check("t3.draw", 32'(result), 32'd3);
        check("t3.over", 32'(game_state), 32'd3);

        // Win on the ninth move is a win, not a draw.
        cur = "win9";
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 1, win9_seq[i]);
            cycle(0, 0, 0, 0);
        end
        check("win9.result_x", 32'(result), 32'd1);
        check("win9.cnt", 32'(move_cnt), 32'd9);

        // Random key traffic against the model.
        cur = "rand";
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 3) == 0);
            kv = ($urandom_range(0, 1) == 1);
            kc = $urandom_range(0, 9);
            if (m_phase == 3 && $urandom_range(0, 3) == 0) kc = 0;
            if (m_phase == 1 && $urandom_range(0, 3) != 0) begin
                empt.delete();
                for (int k = 1; k <= 9; k++) if (m_cells[k] == 0) empt.push_back(k);
                if (empt.size() > 0) kc = empt[$urandom_range(0, empt.size() - 1)];
            end
            cycle(r, s, kv, kc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
